apb_master_bridge: RTL and testbench

Bridges a simple valid/ready command port to the APB bus and returns one response per command. It is the APB master stage that sits directly upstream of the APB slave/RAM block and drives its PSEL/PENABLE/PADDR/PWRITE/PWDATA. It sequences IDLE -> SETUP -> ACCESS, waits for PREADY, captures PRDATA, and aborts with an error flag if the slave does not answer within a bounded number of cycles.

---
 rtl/apb_master_bridge.sv | 127 ++++++++++++
 tb/tb_apb_master_bridge.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
`default_nettype none
// =============================================================================
// apb_master_bridge : valid/ready command port to APB master, one response per
// command, with bounded-wait timeout.                      Revision: 1.0
// =============================================================================
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic                    rsp_valid_q;
  logic                    rsp_error_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;

  assign cnt_d = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            paddr_q   <= cmd_addr;
            pwrite_q  <= cmd_write;
            pwdata_q  <= cmd_wdata;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // Address/data registers are left untouched so they hold last values.
          if (PREADY) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            rsp_error_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_q == C_CNT_LAST) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// =============================================================================
// tb_apb_master_bridge : directed vector bench for apb_master_bridge.
// Revision: 1.0
// =============================================================================
module tb_apb_master_bridge;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        PSEL;
  logic        PENABLE;
  logic [7:0]  PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  logic        use_mem;
  logic [31:0] prdata_drv;
  logic [31:0] mem [256];

  int total_cnt;
  int pass_cnt;

  apb_master_bridge #(
    .ADDR_WIDTH    (8),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // Simple slave memory used by the back-to-back sequence.
  assign PRDATA = use_mem ? mem[PADDR] : prdata_drv;
  always @(posedge PCLK) begin
    if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
  end

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int psel_cycles;
    @(negedge PCLK);
    cmd_valid  = 1'b1;
    cmd_write  = v.wr;
    cmd_addr   = v.addr;
    cmd_wdata  = v.wdata;
    prdata_drv = v.prdata;
    PREADY     = 1'b0;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    // With zero waits, PREADY is already high during SETUP and must be ignored there.
    PREADY = (v.waits == 0);
    chk("setup_psel", PSEL, 1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_paddr", PADDR, v.addr);
    chk("setup_pwrite", PWRITE, v.wr);
    chk("setup_pwdata", PWDATA, v.wdata);
    lat = 0;
    psel_cycles = 1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge PCLK); #1;
      if (e == 1) chk("access_penable", PENABLE, 1);
      if (rsp_valid) begin
        lat = e;
        break;
      end
      if (PSEL) psel_cycles++;
      PREADY = ((e - 1) >= v.waits);
    end
    if (lat == 0) chk("rsp_wait_bound", 0, 1);
    chk("rsp_latency", lat, v.exp_lat);
    chk("psel_cycles", psel_cycles, v.exp_lat);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_error", rsp_error, v.exp_err);
    chk("rsp_psel_low", PSEL, 0);
    chk("rsp_penable_low", PENABLE, 0);
    chk("paddr_hold", PADDR, v.addr);
    chk("pwdata_hold", PWDATA, v.wdata);
    chk("rsp_cmd_ready", cmd_ready, 0);
    PREADY    = 1'b0;
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    chk("hs_rsp_valid", rsp_valid, 0);
    chk("hs_cmd_ready", cmd_ready, 1);
    rsp_ready = 1'b0;
  endtask

  task automatic wait_rsp(input string name, output int lat);
    lat = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge PCLK); #1;
      if (rsp_valid) begin
        lat = e;
        break;
      end
    end
    if (lat == 0) chk(name, 0, 1);
  endtask

  initial begin
    int lat;
    int acc_edge;
    int stale;
    total_cnt = 0;
    pass_cnt  = 0;
    use_mem   = 1'b0;
    prdata_drv = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    //           wr    addr   wdata          waits prdata         exp_rdata      err  lat
    vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF,   0, 32'h12345678, 32'h00000000, 1'b0,  2};
    vecs[1] = '{1'b0, 8'h10, 32'h00000000,   3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0,  5};
    vecs[2] = '{1'b0, 8'h10, 32'h00000000, 100, 32'hCAFEF00D, 32'h00000000, 1'b1, 17};
    vecs[3] = '{1'b1, 8'hFF, 32'h00000000,   1, 32'hFFFFFFFF, 32'h00000000, 1'b0,  3};
    vecs[4] = '{1'b0, 8'h3C, 32'h11111111,   0, 32'h0BADF00D, 32'h0BADF00D, 1'b0,  2};
    vecs[5] = '{1'b0, 8'h01, 32'h00000000,  15, 32'h600DCAFE, 32'h600DCAFE, 1'b0, 17};
    vecs[6] = '{1'b1, 8'h80, 32'hA5A55A5A, 100, 32'h77777777, 32'h00000000, 1'b1, 17};

    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    #1;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_error", rsp_error, 0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Response backpressure: response held, second command refused until handshake.
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20; prdata_drv = 32'hA5A55A5A;
    PREADY = 1'b1;
    @(posedge PCLK); #1;
    cmd_addr = 8'h24; cmd_wdata = 32'h0;
    wait_rsp("bp_rsp_wait", lat);
    chk("bp_latency", lat, 2);
    for (int k = 0; k < 5; k++) begin
      @(posedge PCLK); #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hA5A55A5A);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_no_accept", PSEL, 0);
    end
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    chk("bp_hs_valid", rsp_valid, 0);
    chk("bp_hs_cmd_ready", cmd_ready, 1);
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    chk("bp_second_psel", PSEL, 1);
    chk("bp_second_paddr", PADDR, 8'h24);
    wait_rsp("bp_second_wait", lat);
    chk("bp_second_latency", lat, 2);
    @(posedge PCLK); #1;
    chk("bp_second_hs", rsp_valid, 0);

    // Back-to-back write then read with rsp_ready tied high.
    use_mem = 1'b1;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h00; cmd_wdata = 32'h00000001;
    @(posedge PCLK); #1;
    cmd_write = 1'b0; cmd_wdata = 32'h0;
    acc_edge = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge PCLK); #1;
      if (e == 2) begin
        chk("b2b_wr_rsp_valid", rsp_valid, 1);
        chk("b2b_wr_rdata", rsp_rdata, 0);
      end
      if (cmd_ready) begin
        acc_edge = e + 1;
        break;
      end
    end
    chk("b2b_accept_interval", acc_edge, 4);
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    chk("b2b_rd_pwrite", PWRITE, 0);
    wait_rsp("b2b_rd_wait", lat);
    chk("b2b_rd_latency", lat, 2);
    chk("b2b_rd_rdata", rsp_rdata, 32'h00000001);
    chk("b2b_rd_error", rsp_error, 0);
    @(posedge PCLK); #1;
    rsp_ready = 1'b0;
    use_mem   = 1'b0;
    PREADY    = 1'b0;

    // Asynchronous reset in the middle of ACCESS.
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h44; cmd_wdata = 32'h55555555;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    @(posedge PCLK);
    @(posedge PCLK); #3;
    chk("ar_pre_psel", PSEL, 1);
    chk("ar_pre_penable", PENABLE, 1);
    PRESETn = 1'b0;
    #1;
    chk("ar_psel", PSEL, 0);
    chk("ar_penable", PENABLE, 0);
    chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_paddr", PADDR, 0);
    chk("ar_pwdata", PWDATA, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    #1;
    chk("ar_cmd_ready", cmd_ready, 1);
    PREADY = 1'b1;
    rsp_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge PCLK); #1;
      if (rsp_valid || PSEL) stale++;
    end
    chk("ar_no_stale_rsp", stale, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
